// File: rtl/image_loader_if.sv
`default_nettype none
// ============================================================================
// image_loader_if : UART byte stream in, image-RAM write port and frame status out
// Rev 1.0
// ============================================================================
interface image_loader_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       hold;
    logic [9:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_en;
    logic       loading;
    logic       frame_done;
    logic       timeout_err;
    logic [9:0] pixel_count;

    // master: the loader, which owns the RAM write port and status flags
    modport master (
        input  rx_data, rx_valid, hold,
        output wr_addr, wr_data, wr_en, loading, frame_done, timeout_err, pixel_count
    );

    // slave: UART receiver, image RAM and inference controller side
    modport slave (
        output rx_data, rx_valid, hold,
        input  wr_addr, wr_data, wr_en, loading, frame_done, timeout_err, pixel_count
    );
endinterface
`default_nettype wire

// File: rtl/image_loader.sv
`default_nettype none
// ============================================================================
// image_loader : hunts a two-byte sync header, then writes one frame of pixel
//                bytes into the image RAM; aborts on inter-byte timeout.
// Rev 1.0
// ============================================================================
module image_loader #(
    parameter int         NUM_PIXELS     = 784,
    parameter logic [7:0] SYNC0          = 8'hAA,
    parameter logic [7:0] SYNC1          = 8'h55,
    parameter int         TIMEOUT_CYCLES = 1000000
) (
    input  wire            clk,
    input  wire            rst_n,
    image_loader_if.master io_bus
);

    localparam int              c_GAP_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_GAP_W-1:0] c_GAP_ONE  = c_GAP_W'(1);
    localparam logic [9:0]      c_LAST_ADDR = 10'(NUM_PIXELS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_LOAD = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [c_GAP_W-1:0]   r_gap;
    logic [9:0]           r_pixel_count;
    logic [9:0]           r_wr_addr;
    logic [7:0]           r_wr_data;
    logic                 r_wr_en;
    logic                 r_loading;
    logic                 r_frame_done;
    logic                 r_timeout_err;

    logic                 w_byte;
    logic                 w_in_frame;
    logic                 w_gap_expired;
    logic                 w_timeout;
    logic                 w_pixel_wr;
    logic                 w_start_load;

    assign w_byte        = io_bus.rx_valid;
    assign w_in_frame    = (r_state == ST_SYNC) || (r_state == ST_LOAD);
    assign w_gap_expired = (r_gap == c_GAP_LAST);
    // An arriving byte always beats an expiring gap counter.
    assign w_timeout     = w_in_frame && !w_byte && w_gap_expired;
    assign w_pixel_wr    = (r_state == ST_LOAD) && w_byte;
    assign w_start_load  = (r_state == ST_SYNC) && w_byte && (io_bus.rx_data == SYNC1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_byte && (io_bus.rx_data == SYNC0) && !io_bus.hold) begin
                    w_next_state = ST_SYNC;
                end
            end
            ST_SYNC: begin
                if (w_byte) begin
                    if (io_bus.rx_data == SYNC1) begin
                        w_next_state = ST_LOAD;
                    end else if (io_bus.rx_data == SYNC0) begin
                        w_next_state = ST_SYNC;
                    end else begin
                        w_next_state = ST_IDLE;
                    end
                end else if (w_gap_expired) begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (w_byte) begin
                    if (r_pixel_count == c_LAST_ADDR) begin
                        w_next_state = ST_DONE;
                    end
                end else if (w_gap_expired) begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gap         <= '0;
            r_pixel_count <= '0;
            r_wr_addr     <= '0;
            r_wr_data     <= '0;
            r_wr_en       <= 1'b0;
            r_loading     <= 1'b0;
            r_frame_done  <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_wr_en <= w_pixel_wr;
            if (w_pixel_wr) begin
                r_wr_addr <= r_pixel_count;
                r_wr_data <= io_bus.rx_data;
            end

            // The count survives DONE and timeout so the last frame's size stays visible.
            if (w_start_load) begin
                r_pixel_count <= '0;
            end else if (w_pixel_wr) begin
                r_pixel_count <= r_pixel_count + 10'd1;
            end

            if (!w_in_frame || w_byte || w_timeout) begin
                r_gap <= '0;
            end else begin
                r_gap <= r_gap + c_GAP_ONE;
            end

            r_loading     <= (w_next_state == ST_SYNC) || (w_next_state == ST_LOAD);
            // DONE coincides with the final wr_en, so the flag lands one cycle later.
            r_frame_done  <= (r_state == ST_DONE);
            r_timeout_err <= w_timeout;
        end
    end

    assign io_bus.wr_addr     = r_wr_addr;
    assign io_bus.wr_data     = r_wr_data;
    assign io_bus.wr_en       = r_wr_en;
    assign io_bus.loading     = r_loading;
    assign io_bus.frame_done  = r_frame_done;
    assign io_bus.timeout_err = r_timeout_err;
    assign io_bus.pixel_count = r_pixel_count;

endmodule
`default_nettype wire
